// File: rtl/tagged_mem.sv
// Tagged 64+8-bit memory slave on the CPU strobe bus: address latch, then single/burst reads and writes.
// Read data valid one cycle after i_rd is sampled; o_err one cycle after an offence; no backpressure.
module tagged_mem #(
    parameter int AW = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] i_ad,
    input  logic [7:0]  i_tag,
    input  logic        i_astb,
    input  logic        i_rd,
    input  logic        i_wr,
    output logic [63:0] o_data,
    output logic [7:0]  o_tag,
    output logic        o_valid,
    output logic        o_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OPEN  = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   waddr;
    logic [AW-1:0]   waddr_nxt;
    logic [AW-1:0]   waddr_inc;
    logic            addr_ok;
    logic            mem_we;
    logic            rd_en;
    logic            err_nxt;

    logic [71:0]     mem [0:(2**AW)-1];

    assign waddr_inc = waddr + AW'(1);
    assign addr_ok   = (i_ad[63:AW] == '0);

    // Strobe wins over write, write wins over read; a write+read pair keeps the write.
    always_comb begin
        state_nxt = state;
        waddr_nxt = waddr;
        mem_we    = 1'b0;
        rd_en     = 1'b0;
        err_nxt   = 1'b0;
        if (i_astb) begin
            if (addr_ok) begin
                state_nxt = OPEN;
                waddr_nxt = i_ad[AW-1:0];
            end else begin
                state_nxt = FAULT;
            end
        end else if (i_wr || i_rd) begin
            if (state == OPEN) begin
                waddr_nxt = waddr_inc;
                if (i_wr) begin
                    mem_we  = 1'b1;
                    err_nxt = i_rd;
                end else begin
                    rd_en   = 1'b1;
                end
            end else begin
                err_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            waddr   <= '0;
            o_valid <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            state   <= state_nxt;
            waddr   <= waddr_nxt;
            o_valid <= rd_en;
            o_err   <= err_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_data <= '0;
            o_tag  <= '0;
        end else if (rd_en) begin
            {o_data, o_tag} <= mem[waddr];
        end
    end

    // RAM array carries no reset so it can map onto block memory.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[waddr] <= {i_ad, i_tag};
        end
    end

endmodule

// File: tb/tb_tagged_mem.sv
// Self-checking bench for tagged_mem: directed scenarios plus a randomized run against a word-level model.
module tb_tagged_mem;

    localparam int AW    = 20;
    localparam int DEPTH = 2 ** AW;

    logic        clk;
    logic        reset;
    logic [63:0] i_ad;
    logic [7:0]  i_tag;
    logic        i_astb;
    logic        i_rd;
    logic        i_wr;
    logic [63:0] o_data;
    logic [7:0]  o_tag;
    logic        o_valid;
    logic        o_err;

    tagged_mem #(.AW(AW)) dut (
        .clk     (clk),
        .reset   (reset),
        .i_ad    (i_ad),
        .i_tag   (i_tag),
        .i_astb  (i_astb),
        .i_rd    (i_rd),
        .i_wr    (i_wr),
        .o_data  (o_data),
        .o_tag   (o_tag),
        .o_valid (o_valid),
        .o_err   (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    // Reference model: "have an address?", "is it usable?", the address, and the written words.
    bit          m_have_addr;
    bit          m_addr_bad;
    int          m_addr;
    logic [71:0] m_mem [int];
    logic [71:0] m_held;
    bit          m_held_known;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_have_addr  = 0;
        m_addr_bad   = 0;
        m_addr       = 0;
        m_held       = '0;
        m_held_known = 1;
    endtask

    task automatic step(input string tag, input logic astb, input logic rd, input logic wr,
                        input logic [63:0] ad, input logic [7:0] tg);
        bit exp_valid;
        bit exp_err;
        i_astb = astb;
        i_rd   = rd;
        i_wr   = wr;
        i_ad   = ad;
        i_tag  = tg;
        @(posedge clk);
        #1;
        exp_valid = 0;
        exp_err   = 0;
        if (astb) begin
            m_have_addr = 1;
            m_addr_bad  = (ad >= 64'(DEPTH));
            if (!m_addr_bad) m_addr = int'(ad);
        end else if (rd || wr) begin
            if (!m_have_addr || m_addr_bad) begin
                exp_err = 1;
            end else begin
                if (wr) begin
                    m_mem[m_addr] = {ad, tg};
                    exp_err = rd;
                end else begin
                    exp_valid = 1;
                    m_held_known = m_mem.exists(m_addr);
                    if (m_held_known) m_held = m_mem[m_addr];
                end
                m_addr = (m_addr + 1) % DEPTH;
            end
        end
        check({tag, ".valid"}, 72'(o_valid), 72'(exp_valid));
        check({tag, ".err"}, 72'(o_err), 72'(exp_err));
        if (m_held_known) check({tag, ".data_tag"}, {o_data, o_tag}, m_held);
    endtask

    task automatic astb(input string tag, input logic [63:0] a);
        step(tag, 1'b1, 1'b0, 1'b0, a, 8'h00);
    endtask

    task automatic wr(input string tag, input logic [63:0] d, input logic [7:0] t);
        step(tag, 1'b0, 1'b0, 1'b1, d, t);
    endtask

    task automatic rd(input string tag);
        step(tag, 1'b0, 1'b1, 1'b0, 64'h0, 8'h00);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, 64'h0, 8'h00);
    endtask

    initial begin
        logic [63:0] a;
        int          r;
        checks   = 0;
        failures = 0;
        reset  = 1'b0;
        i_ad   = '0;
        i_tag  = '0;
        i_astb = 1'b0;
        i_rd   = 1'b0;
        i_wr   = 1'b0;
        model_reset();

        #2;
        check("reset.valid", 72'(o_valid), 72'(0));
        check("reset.err", 72'(o_err), 72'(0));
        check("reset.data_tag", {o_data, o_tag}, 72'(0));
        #10 reset = 1'b1;

        // Read with no address latched.
        rd("rd_no_addr");
        idle("rd_no_addr_after");

        // Burst write then burst read.
        astb("b.astb", 64'h100);
        for (int i = 0; i < 3; i++) wr("b.wr", 64'hA0 + 64'(i), 8'h11 + 8'(i));
        astb("b.astb2", 64'h100);
        for (int i = 0; i < 3; i++) rd("b.rd");
        check("b.last_data", 72'(o_data), 72'(64'hA2));
        check("b.last_tag", 72'(o_tag), 72'(8'h13));
        idle("b.idle");

        // Address wrap at the top of the space.
        astb("w.astb", 64'hFFFFF);
        wr("w.wr0", 64'h55, 8'h21);
        wr("w.wr1", 64'h66, 8'h22);
        astb("w.astb2", 64'hFFFFF);
        rd("w.rd0");
        check("w.rd0_data", 72'(o_data), 72'(64'h55));
        rd("w.rd1");
        check("w.rd1_data", 72'(o_data), 72'(64'h66));

        // Out-of-range address faults writes; re-strobe recovers.
        astb("f.astb", 64'h100000);
        wr("f.wr", 64'hDEAD, 8'hEE);
        rd("f.rd");
        astb("f.astb0", 64'h0);
        rd("f.rd0");
        check("f.mem0_kept", 72'(o_data), 72'(64'h66));

        // Write+read conflict keeps the write and advances once.
        astb("c.astb6", 64'h6);
        wr("c.wr6", 64'h88, 8'h31);
        astb("c.astb5", 64'h5);
        step("c.wr_rd", 1'b0, 1'b1, 1'b1, 64'h77, 8'h32);
        rd("c.rd6");
        check("c.waddr_is_6", 72'(o_data), 72'(64'h88));
        astb("c.astb5b", 64'h5);
        rd("c.rd5");
        check("c.mem5", {o_data, o_tag}, {64'h77, 8'h32});
        step("c.astb_rd", 1'b1, 1'b1, 1'b0, 64'h100, 8'h00);
        rd("c.rd100");
        check("c.astb_latched", 72'(o_data), 72'(64'hA0));

        // Randomized traffic over a small window, the wrap region and bad addresses.
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                case ($urandom_range(0, 3))
                    0:       a = 64'($urandom_range(0, 15));
                    1:       a = 64'(DEPTH - 8 + int'($urandom_range(0, 7)));
                    2:       a = {$urandom, $urandom} | 64'(DEPTH);
                    default: a = 64'(DEPTH);
                endcase
                step("rnd.astb", 1'b1, 1'($urandom), 1'($urandom), a, 8'($urandom));
            end else begin
                step("rnd.cmd", 1'b0, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) == 0),
                     {$urandom, $urandom}, 8'($urandom));
            end
        end

        // Reset asserted in the middle of a read burst, away from a clock edge.
        astb("r.astb", 64'h100);
        rd("r.rd0");
        rd("r.rd1");
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("r.valid0", 72'(o_valid), 72'(0));
        check("r.err0", 72'(o_err), 72'(0));
        check("r.data0", {o_data, o_tag}, 72'(0));
        i_rd = 1'b0;
        #3 reset = 1'b1;
        rd("r.rd_after");
        idle("r.idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tagged_mem.md
# tagged_mem

Synthesizable tagged main-memory slave on the CPU's strobe bus: consumes `o_ad`/`o_tag`/`o_astb`/`o_rd`/`o_wr` from `cpu` and returns `i_data`/`i_tag`. Latches a word address on the address strobe, then serves single or batch (auto-incrementing) 64-bit data + 8-bit tag reads and writes from an internal RAM. Replaces the behavioural memory in simulation and is the FPGA memory stage directly downstream of the CPU.

## Interface
- `AW`, 20: word-address width; RAM depth is 2**AW words of 64+8 bits.
- `clk`  input  1  system clock, all state on rising edge.
- `reset`  input  1  asynchronous, active-low reset (asserted at 0).
- `i_ad`  input  64  address (when `i_astb`) or write data (when `i_wr`); driven by CPU `o_ad`.
- `i_tag`  input  8  write tag; driven by CPU `o_tag`.
- `i_astb`  input  1  address strobe.
- `i_rd`  input  1  read request.
- `i_wr`  input  1  write request.
- `o_data`  output  64  read data; to CPU `i_data`.
- `o_tag`  output  8  read tag; to CPU `i_tag`.
- `o_valid`  output  1  one-cycle pulse, `o_data`/`o_tag` updated by a read.
- `o_err`  output  1  one-cycle pulse, rejected or conflicting access.

## Operation
- States: IDLE (no address latched), OPEN (valid address in `waddr`), FAULT (out-of-range address latched).
- Command priority per edge: `i_astb` > `i_wr` > `i_rd`.
- `i_astb` (any state): if `i_ad[63:AW]`==0 -> `waddr`<=`i_ad[AW-1:0]`, state OPEN; else state FAULT, `waddr` unchanged. Concurrent `i_wr`/`i_rd` ignored, no error.
- `i_wr` in OPEN: mem[`waddr`]<={`i_ad`,`i_tag`}; `waddr`<=`waddr`+1.
- `i_rd` in OPEN (no `i_wr`): {`o_data`,`o_tag`}<=mem[`waddr`]; `o_valid` pulse; `waddr`<=`waddr`+1.
- `i_wr` and `i_rd` together in OPEN: write performed as above, read dropped, `o_err` pulse, `o_valid` stays 0, `waddr` incremented once.
- `i_rd` or `i_wr` in IDLE or FAULT: no RAM access, no address change, `o_err` pulse, `o_data`/`o_tag` held.
- Increment is modulo 2**AW: from all-ones wraps to 0, stays OPEN, no error.
- `o_data`/`o_tag` hold last read value until the next successful read.
- RAM contents are not cleared by reset; after reset they are undefined for synthesis (X in simulation) until written.

## Timing
- Reset (async assert, sync release): state IDLE, `waddr`=0, `o_data`=0, `o_tag`=0, `o_valid`=0, `o_err`=0.
- Reset mid-burst: burst abandoned, returns to IDLE; a new `i_astb` is required.
- Address latch: `i_astb` sampled at edge N; first `i_rd`/`i_wr` accepted at edge N+1 at earliest (back-to-back legal).
- Read latency 1: `i_rd` sampled at edge N -> `o_data`/`o_tag`/`o_valid` valid after edge N, i.e. during cycle N+1; `o_valid` low again after edge N+1 unless another read.
- Burst: `i_rd` high for K consecutive edges -> K consecutive `o_valid` cycles, ascending addresses, one word per clock, no bubbles.
- Write takes effect at the sampling edge; a read of the same address at the next edge returns the new data/tag.
- `o_err` is registered: asserted during cycle N+1 for an offending command sampled at edge N, for exactly one cycle per offence.
- No backpressure: every command is accepted or rejected in its own cycle.

## Test plan
- Reset then `i_rd` without `i_astb` -> `o_err`=1 one cycle, `o_valid`=0, `o_data`=0, `o_tag`=0.
- `i_astb` `i_ad`=0x100; write 3 words 0xA0..0xA2 tags 0x11..0x13; `i_astb` 0x100; `i_rd` 3 cycles -> `o_valid` 3 consecutive cycles with 0xA0/0x11, 0xA1/0x12, 0xA2/0x13.
- Wrap: `i_astb` 0xFFFFF, write 0x55 then 0x66 -> read from 0xFFFFF returns 0x55, read from 0 returns 0x66; no `o_err`.
- `i_astb` with `i_ad`=0x100000 (AW=20) then `i_wr` -> `o_err` pulse, mem[0] unchanged; next `i_astb` 0 restores OPEN, reads work.
- `i_wr`+`i_rd` same cycle at address 5, data 0x77 -> `o_err` pulse, no `o_valid`, mem[5]=0x77, `waddr`=6; `i_astb`+`i_rd` same cycle -> address latched, no read, no error.
- Assert `reset`=0 mid read burst at arbitrary phase (not on edge) -> outputs 0 immediately; after release `i_rd` gives `o_err`.
